sata_fis_tx_scheduler: RTL and testbench

Arbitrates two transmit requesters (command/register FIS path, data FIS path) onto the single write interface of the SATA link layer. Sequences each frame: waits for an idle link, launches the write, forwards data strobes, and retries on transmit error. Enforces a no-progress timeout with abort. Sits between the transport layer and the link layer; yields to inbound receive traffic.

---
 rtl/sata_fis_tx_scheduler_pkg.sv | 21 ++
 rtl/sata_fis_tx_scheduler_arbiter.sv | 37 +++
 rtl/sata_fis_tx_scheduler.sv | 178 +++++++++++++++++
 tb/tb_sata_fis_tx_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_fis_tx_scheduler_pkg.sv
// Shared types for the SATA FIS transmit scheduler: FSM state codes, requester IDs, defaults.
// Pure declarations; no latency or backpressure of its own.
package sata_fis_tx_scheduler_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_LINK = 4'd1,
    ST_START     = 4'd2,
    ST_ACTIVE    = 4'd3,
    ST_ABORT     = 4'd4
  } tx_state_t;

  typedef enum logic {
    REQ_CMD = 1'b0,
    REQ_DAT = 1'b1
  } req_id_t;

  localparam int unsigned DEF_MAX_RETRY = 3;
  localparam logic [15:0] DEF_TIMEOUT   = 16'd4096;

endpackage

// File: rtl/sata_fis_tx_scheduler_arbiter.sv
// Two-way round-robin pick between cmd and dat requesters; combinational grant, registered last winner.
// Zero latency; the caller decides when a grant is committed via i_update.
module sata_rr_arbiter2
  import sata_fis_tx_scheduler_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  req_id_t    i_winner,
  output logic       o_any,
  output req_id_t    o_grant
);

  req_id_t r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= REQ_DAT;
    end else if (i_update) begin
      r_last <= i_winner;
    end
  end

  // On a tie, the requester that did not win last time goes first.
  always_comb begin
    o_grant = REQ_CMD;
    if (i_req[REQ_CMD] && i_req[REQ_DAT]) begin
      o_grant = (r_last == REQ_DAT) ? REQ_CMD : REQ_DAT;
    end else if (i_req[REQ_DAT]) begin
      o_grant = REQ_DAT;
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/sata_fis_tx_scheduler.sv
// Schedules cmd/dat FIS frames onto the link write port with retry, timeout abort and rx yield.
// Request to write_start is 3 cycles minimum; stalls while the link is busy or receiving.
module sata_fis_tx_scheduler
  import sata_fis_tx_scheduler_pkg::*;
#(
  parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
  parameter logic [15:0] TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_link_layer_ready,
  input  logic        i_read_start,
  input  logic        i_read_finished,
  output logic        o_write_start,
  output logic [31:0] o_write_size,
  output logic [31:0] o_write_data,
  output logic        o_write_hold,
  output logic        o_write_abort,
  input  logic        i_write_strobe,
  input  logic        i_write_finished,
  input  logic        i_xmit_error,
  input  logic        i_cmd_req,
  input  logic [31:0] i_cmd_size,
  input  logic [31:0] i_cmd_data,
  input  logic        i_cmd_hold,
  output logic        o_cmd_strobe,
  output logic        o_cmd_restart,
  output logic        o_cmd_done,
  output logic        o_cmd_error,
  input  logic        i_dat_req,
  input  logic [31:0] i_dat_size,
  input  logic [31:0] i_dat_data,
  input  logic        i_dat_hold,
  output logic        o_dat_strobe,
  output logic        o_dat_restart,
  output logic        o_dat_done,
  output logic        o_dat_error,
  output logic [3:0]  o_state
);

  localparam logic [7:0]  LP_MAX_RETRY = 8'(MAX_RETRY);
  localparam logic [15:0] LP_TO_LAST   = TIMEOUT - 16'd1;

  tx_state_t   r_state;
  req_id_t     r_grant;
  logic        r_rx_busy;
  logic [15:0] r_to_cnt;
  logic [7:0]  r_retry_cnt;
  logic        r_write_start;
  logic        r_write_abort;
  logic [31:0] r_write_size;
  logic [1:0]  r_done;
  logic [1:0]  r_error;
  logic [1:0]  r_restart;

  logic        w_any;
  req_id_t     w_pick;
  logic [31:0] w_pick_size;
  logic        w_active;
  logic        w_commit;

  sata_rr_arbiter2 u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    ({i_dat_req, i_cmd_req}),
    .i_update (w_commit),
    .i_winner (r_grant),
    .o_any    (w_any),
    .o_grant  (w_pick)
  );

  assign w_pick_size = (w_pick == REQ_DAT) ? i_dat_size : i_cmd_size;
  assign w_active    = (r_state == ST_ACTIVE);
  assign w_commit    = w_active && i_write_finished && !i_xmit_error;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= REQ_CMD;
      r_rx_busy     <= 1'b0;
      r_to_cnt      <= 16'd0;
      r_retry_cnt   <= 8'd0;
      r_write_start <= 1'b0;
      r_write_abort <= 1'b0;
      r_write_size  <= 32'd0;
      r_done        <= 2'b00;
      r_error       <= 2'b00;
      r_restart     <= 2'b00;
    end else begin
      r_write_start <= 1'b0;
      r_write_abort <= 1'b0;
      r_done        <= 2'b00;
      r_error       <= 2'b00;
      r_restart     <= 2'b00;

      if (i_read_start) begin
        r_rx_busy <= 1'b1;
      end else if (i_read_finished) begin
        r_rx_busy <= 1'b0;
      end

      case (r_state)
        // A requester still sees its done pulse this cycle and has not yet dropped req.
        ST_IDLE: begin
          if (w_any && (r_done == 2'b00)) begin
            r_grant      <= w_pick;
            r_write_size <= w_pick_size;
            r_retry_cnt  <= 8'd0;
            if (w_pick_size == 32'd0) begin
              r_done[w_pick]  <= 1'b1;
              r_error[w_pick] <= 1'b1;
            end else begin
              r_state <= ST_WAIT_LINK;
            end
          end
        end
        ST_WAIT_LINK: begin
          if (i_link_layer_ready && !r_rx_busy) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_write_start <= 1'b1;
          r_to_cnt      <= 16'd0;
          r_state       <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (i_write_finished) begin
            if (!i_xmit_error) begin
              r_done[r_grant] <= 1'b1;
              r_state         <= ST_IDLE;
            end else if (r_retry_cnt < LP_MAX_RETRY) begin
              r_retry_cnt        <= r_retry_cnt + 8'd1;
              r_restart[r_grant] <= 1'b1;
              r_state            <= ST_WAIT_LINK;
            end else begin
              r_done[r_grant]  <= 1'b1;
              r_error[r_grant] <= 1'b1;
              r_state          <= ST_IDLE;
            end
          end else if (i_write_strobe) begin
            r_to_cnt <= 16'd0;
          end else if (r_to_cnt == LP_TO_LAST) begin
            r_write_abort <= 1'b1;
            r_state       <= ST_ABORT;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        ST_ABORT: begin
          if (i_link_layer_ready) begin
            r_done[r_grant]  <= 1'b1;
            r_error[r_grant] <= 1'b1;
            r_state          <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_write_data  = (r_grant == REQ_DAT) ? i_dat_data : i_cmd_data;
  assign o_write_hold  = (r_grant == REQ_DAT) ? i_dat_hold : i_cmd_hold;
  assign o_cmd_strobe  = w_active && (r_grant == REQ_CMD) && i_write_strobe;
  assign o_dat_strobe  = w_active && (r_grant == REQ_DAT) && i_write_strobe;

  assign o_write_start = r_write_start;
  assign o_write_abort = r_write_abort;
  assign o_write_size  = r_write_size;
  assign o_cmd_done    = r_done[REQ_CMD];
  assign o_cmd_error   = r_error[REQ_CMD];
  assign o_cmd_restart = r_restart[REQ_CMD];
  assign o_dat_done    = r_done[REQ_DAT];
  assign o_dat_error   = r_error[REQ_DAT];
  assign o_dat_restart = r_restart[REQ_DAT];
  assign o_state       = r_state;

endmodule

// File: tb/tb_sata_fis_tx_scheduler.sv
// Directed bench: bench acts as link and both requesters; a frame-level model predicts every output each cycle.
module tb_sata_fis_tx_scheduler;

  localparam int          TIMEOUT   = 4096;
  localparam int          MAX_RETRY = 3;
  localparam logic [31:0] CMD_BASE  = 32'hC0DE_0000;
  localparam logic [31:0] DAT_BASE  = 32'hDA7A_0000;
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_START = 2, PH_WIRE = 3, PH_ABORT = 4;

  logic        clk, rst, link_layer_ready, read_start, read_finished;
  logic        write_start, write_abort, write_hold;
  logic [31:0] write_size, write_data;
  logic        write_strobe, write_finished, xmit_error;
  logic        cmd_req, cmd_hold, cmd_strobe, cmd_restart, cmd_done, cmd_error;
  logic [31:0] cmd_size, cmd_data;
  logic        dat_req, dat_hold, dat_strobe, dat_restart, dat_done, dat_error;
  logic [31:0] dat_size, dat_data;
  logic [3:0]  state;

  sata_fis_tx_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_link_layer_ready(link_layer_ready),
    .i_read_start(read_start), .i_read_finished(read_finished),
    .o_write_start(write_start), .o_write_size(write_size), .o_write_data(write_data),
    .o_write_hold(write_hold), .o_write_abort(write_abort),
    .i_write_strobe(write_strobe), .i_write_finished(write_finished), .i_xmit_error(xmit_error),
    .i_cmd_req(cmd_req), .i_cmd_size(cmd_size), .i_cmd_data(cmd_data), .i_cmd_hold(cmd_hold),
    .o_cmd_strobe(cmd_strobe), .o_cmd_restart(cmd_restart), .o_cmd_done(cmd_done), .o_cmd_error(cmd_error),
    .i_dat_req(dat_req), .i_dat_size(dat_size), .i_dat_data(dat_data), .i_dat_hold(dat_hold),
    .o_dat_strobe(dat_strobe), .o_dat_restart(dat_restart), .o_dat_done(dat_done), .o_dat_error(dat_error),
    .o_state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0, n_fail = 0;

  // model of the frame in flight and of the pulses due next cycle
  int          m_ph = PH_IDLE, m_own = 0, m_last = 1, m_tries = 0, m_quiet = 0;
  bit          m_busy = 0;
  logic [31:0] m_size = 32'd0;
  bit          e_start = 0, e_abort = 0;
  bit [1:0]    e_done = 2'b00, e_err = 2'b00, e_rst = 2'b00;

  // observations of the DUT
  int cyc = 0, t_ws = 0, t_wf = 0, t_done = 0, t_abort = 0;
  int n_ws = 0, n_cmd_strobe = 0, n_dat_restart = 0, n_done = 0, last_who = 0, last_err = 0;
  bit sv_start, sv_abort, sv_done, sv_cmd_strobe, sv_dat_strobe;
  bit sv_cmd_restart, sv_dat_restart, sv_cmd_done, sv_dat_done;
  int cmd_idx = 0, dat_idx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    bit [1:0] prev_done;
    bit       xs;
    cyc++;
    xs = (m_ph == PH_WIRE) && write_strobe;
    chk("write_start", write_start, e_start);
    chk("write_abort", write_abort, e_abort);
    chk("write_size", write_size, m_size);
    chk("cmd_done", cmd_done, e_done[0]);
    chk("cmd_error", cmd_error, e_err[0]);
    chk("cmd_restart", cmd_restart, e_rst[0]);
    chk("dat_done", dat_done, e_done[1]);
    chk("dat_error", dat_error, e_err[1]);
    chk("dat_restart", dat_restart, e_rst[1]);
    chk("cmd_strobe", cmd_strobe, xs && (m_own == 0));
    chk("dat_strobe", dat_strobe, xs && (m_own == 1));
    if (m_ph == PH_WIRE) begin
      chk("write_data", write_data, (m_own == 1) ? dat_data : cmd_data);
      chk("write_hold", write_hold, (m_own == 1) ? dat_hold : cmd_hold);
    end

    sv_start = write_start;   sv_abort = write_abort;
    sv_cmd_strobe = cmd_strobe; sv_dat_strobe = dat_strobe;
    sv_cmd_restart = cmd_restart; sv_dat_restart = dat_restart;
    sv_cmd_done = cmd_done;   sv_dat_done = dat_done;
    sv_done = cmd_done || dat_done;
    if (write_start) begin t_ws = cyc; n_ws++; end
    if (write_abort) t_abort = cyc;
    if (write_finished) t_wf = cyc;
    if (cmd_strobe) n_cmd_strobe++;
    if (dat_restart) n_dat_restart++;
    if (sv_done) begin
      t_done = cyc; n_done++;
      last_who = dat_done ? 1 : 0;
      last_err = (cmd_error || dat_error) ? 1 : 0;
    end

    prev_done = e_done;
    e_start = 0; e_abort = 0; e_done = 2'b00; e_err = 2'b00; e_rst = 2'b00;
    if (rst) begin
      m_ph = PH_IDLE; m_last = 1; m_busy = 0; m_size = 32'd0; m_own = 0; m_tries = 0; m_quiet = 0;
    end else begin
      case (m_ph)
        PH_IDLE: if ((cmd_req || dat_req) && prev_done == 2'b00) begin
          if (cmd_req && dat_req) m_own = 1 - m_last;
          else m_own = dat_req ? 1 : 0;
          m_size = (m_own == 1) ? dat_size : cmd_size;
          m_tries = 0;
          if (m_size == 32'd0) begin e_done[m_own] = 1; e_err[m_own] = 1; end
          else m_ph = PH_WAIT;
        end
        PH_WAIT: if (link_layer_ready && !m_busy) m_ph = PH_START;
        PH_START: begin e_start = 1; m_quiet = 0; m_ph = PH_WIRE; end
        PH_WIRE: if (write_finished) begin
          if (!xmit_error) begin e_done[m_own] = 1; m_last = m_own; m_ph = PH_IDLE; end
          else if (m_tries < MAX_RETRY) begin m_tries++; e_rst[m_own] = 1; m_ph = PH_WAIT; end
          else begin e_done[m_own] = 1; e_err[m_own] = 1; m_ph = PH_IDLE; end
        end else begin
          m_quiet = write_strobe ? 0 : m_quiet + 1;
          if (m_quiet == TIMEOUT) begin e_abort = 1; m_ph = PH_ABORT; end
        end
        PH_ABORT: if (link_layer_ready) begin e_done[m_own] = 1; e_err[m_own] = 1; m_ph = PH_IDLE; end
        default: m_ph = PH_IDLE;
      endcase
      if (read_start) m_busy = 1;
      else if (read_finished) m_busy = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (sv_cmd_done) begin cmd_req = 0; cmd_idx = 0; end
    else if (sv_cmd_restart) cmd_idx = 0;
    else if (sv_cmd_strobe) cmd_idx++;
    if (sv_dat_done) begin dat_req = 0; dat_idx = 0; end
    else if (sv_dat_restart) dat_idx = 0;
    else if (sv_dat_strobe) dat_idx++;
    cmd_data = CMD_BASE + 32'(cmd_idx);
    dat_data = DAT_BASE + 32'(dat_idx);
  endtask

  task automatic wait_for(input int what, input int bound, input string nm);
    int k;
    bit hit;
    k = 0; hit = 0;
    while (!hit && k < bound) begin
      step();
      k++;
      hit = (what == 0) ? sv_start : (what == 1) ? sv_done : sv_abort;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: no event within %0d cycles (got 0, expected 1)", nm, bound);
    end
  endtask

  task automatic link_frame(input int n, input bit err);
    for (int i = 0; i < n; i++) begin
      write_strobe = 1;
      step();
    end
    write_strobe = 0;
    write_finished = 1;
    xmit_error = err;
    step();
    write_finished = 0;
    xmit_error = 0;
  endtask

  initial begin
    int t_req, t_rdy, t_rf, saved;
    int order[4];
    int exp_order[4] = '{0, 1, 0, 1};
    rst = 1; link_layer_ready = 1; read_start = 0; read_finished = 0;
    write_strobe = 0; write_finished = 0; xmit_error = 0;
    cmd_req = 0; cmd_size = 0; cmd_hold = 0; cmd_data = CMD_BASE;
    dat_req = 0; dat_size = 0; dat_hold = 0; dat_data = DAT_BASE;

    repeat (3) step();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_write_size", write_size, 32'd0);
    rst = 0;
    step();

    // single cmd frame, 5 dwords
    cmd_size = 5; cmd_req = 1; n_cmd_strobe = 0;
    step(); t_req = cyc;
    wait_for(0, 10, "t1_start");
    chk("t1_req_to_start", 32'(t_ws - t_req), 32'd3);
    chk("t1_write_size", write_size, 32'd5);
    cmd_hold = 1; step(); cmd_hold = 0;
    link_frame(5, 0);
    wait_for(1, 5, "t1_done");
    chk("t1_strobes", 32'(n_cmd_strobe), 32'd5);
    chk("t1_done_latency", 32'(t_done - t_wf), 32'd1);
    chk("t1_done_who", 32'(last_who), 32'd0);
    chk("t1_done_err", 32'(last_err), 32'd0);

    // round robin from reset: both always pending for the first two frames
    rst = 1; step(); step(); rst = 0;
    cmd_size = 2; dat_size = 3; cmd_req = 1; dat_req = 1;
    for (int f = 0; f < 4; f++) begin
      wait_for(0, 10, "t2_start");
      link_frame(2, 0);
      wait_for(1, 5, "t2_done");
      order[f] = last_who;
      if (f < 2) begin
        if (last_who == 0) cmd_req = 1; else dat_req = 1;
      end
    end
    for (int f = 0; f < 4; f++) chk("t2_grant_order", 32'(order[f]), 32'(exp_order[f]));

    // dat frame failing on every attempt
    dat_size = 4; dat_req = 1; n_ws = 0; n_dat_restart = 0;
    for (int r = 0; r < 4; r++) begin
      wait_for(0, 10, "t3_start");
      link_frame(2, 1);
    end
    wait_for(1, 5, "t3_done");
    chk("t3_write_starts", 32'(n_ws), 32'd4);
    chk("t3_restarts", 32'(n_dat_restart), 32'd3);
    chk("t3_done_who", 32'(last_who), 32'd1);
    chk("t3_done_err", 32'(last_err), 32'd1);

    // zero-length frame
    dat_size = 0; dat_req = 1; n_ws = 0;
    step(); t_req = cyc;
    wait_for(1, 5, "t4_done");
    chk("t4_done_latency", 32'(t_done - t_req), 32'd1);
    chk("t4_done_err", 32'(last_err), 32'd1);
    repeat (4) step();
    chk("t4_no_write_start", 32'(n_ws), 32'd0);

    // no-progress timeout, abort held off until the link is ready
    cmd_size = 8; cmd_req = 1;
    wait_for(0, 10, "t5_start");
    link_layer_ready = 0;
    wait_for(2, 5000, "t5_abort");
    chk("t5_abort_after", 32'(t_abort - t_ws), 32'd4096);
    saved = n_done;
    repeat (3) step();
    chk("t5_no_done_while_busy", 32'(n_done), 32'(saved));
    link_layer_ready = 1;
    step(); t_rdy = cyc;
    wait_for(1, 5, "t5_done");
    chk("t5_done_latency", 32'(t_done - t_rdy), 32'd1);
    chk("t5_done_err", 32'(last_err), 32'd1);

    // inbound frame holds off launch; start and finish together leave rx busy
    read_start = 1; read_finished = 1; step(); read_start = 0; read_finished = 0;
    cmd_size = 1; cmd_req = 1; n_ws = 0;
    repeat (19) step();
    chk("t6_held_off", 32'(n_ws), 32'd0);
    read_finished = 1; step(); t_rf = cyc; read_finished = 0;
    wait_for(0, 10, "t6_start");
    chk("t6_rf_to_start", 32'(t_ws - t_rf), 32'd3);
    link_frame(1, 0);
    wait_for(1, 5, "t6_done");
    chk("t6_done_err", 32'(last_err), 32'd0);

    // reset mid-frame drops it silently, then the still-pending request is served
    cmd_size = 3; cmd_req = 1;
    wait_for(0, 10, "t7_start");
    write_strobe = 1; step(); write_strobe = 0;
    saved = n_done;
    rst = 1; step(); rst = 0;
    repeat (2) step();
    chk("t7_no_done_after_rst", 32'(n_done), 32'(saved));
    wait_for(0, 10, "t7_restart");
    link_frame(3, 0);
    wait_for(1, 5, "t7_done");
    chk("t7_done_who", 32'(last_who), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
